// File: rtl/rom_dl_router.sv
// Purpose: route the HPS ioctl download byte stream into per-region ROM/PROM write ports.
// Latency: one cycle from DL_WR to WR_EN/WR_CS/WR_ADDR/WR_DATA and counter updates.
// Backpressure: none; every in-range byte in LOAD is strobed, back-to-back bytes included.
module rom_dl_router #(
   parameter int                              NUM_REGIONS  = 4,
   parameter int                              ADDR_W       = 25,
   parameter int                              LOCAL_AW     = 15,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE  = {25'h12000, 25'h10000, 25'h08000, 25'h00000},
   parameter logic [ADDR_W-1:0]               REGION_LIMIT = 25'h14000,
   parameter int                              IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   DL_ACTIVE,
   input  logic                   DL_WR,
   input  logic [ADDR_W-1:0]      DL_ADDR,
   input  logic [7:0]             DL_DATA,
   output logic                   WR_EN,
   output logic [NUM_REGIONS-1:0] WR_CS,
   output logic [LOCAL_AW-1:0]    WR_ADDR,
   output logic [7:0]             WR_DATA,
   output logic [IDX_W-1:0]       REGION_IDX,
   output logic [NUM_REGIONS-1:0] LOADED,
   output logic                   DL_DONE,
   output logic                   DL_ERR,
   output logic [ADDR_W-1:0]      BYTE_CNT,
   output logic [7:0]             CHECKSUM
);

   // Region edges: entry i is the base of region i, entry NUM_REGIONS is the exclusive limit,
   // so region i spans [EDGES[i], EDGES[i+1]).
   localparam logic [(NUM_REGIONS+1)*ADDR_W-1:0] EDGES = {REGION_LIMIT, REGION_BASE};

   // Configuration sanity, caught at elaboration.
   if (NUM_REGIONS < 1 || NUM_REGIONS > 32) begin : g_bad_count
      $error("rom_dl_router: NUM_REGIONS must be 1..32");
   end
   if (REGION_BASE[ADDR_W-1:0] != '0) begin : g_bad_first_base
      $error("rom_dl_router: region 0 must start at address 0");
   end
   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_chk
      localparam logic [ADDR_W-1:0] LO = EDGES[g*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] HI = EDGES[(g+1)*ADDR_W +: ADDR_W];
      if (HI <= LO) begin : g_bad_order
         $error("rom_dl_router: region bases/limit not strictly ascending");
      end
      if (64'(HI - LO) > (64'd1 << LOCAL_AW)) begin : g_bad_size
         $error("rom_dl_router: region larger than local address space");
      end
   end

   typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

   state_t                 state_q, state_d;
   logic                   act_q;
   logic                   rise;
   logic                   start;
   logic [IDX_W-1:0]       hit_idx;
   logic [ADDR_W-1:0]      hit_base, hit_end, local_full;
   logic [NUM_REGIONS-1:0] hit_onehot;
   logic                   in_range, is_last, accept, non_mono, err_evt;
   logic [ADDR_W-1:0]      last_addr;

   assign rise    = DL_ACTIVE & ~act_q;
   assign DL_DONE = (state_q == FINISH);

   // Priority decode: highest region whose base is at or below the address.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (DL_ADDR >= EDGES[i*ADDR_W +: ADDR_W]) hit_idx = IDX_W'(i);
      end
      hit_base   = EDGES[int'(hit_idx)*ADDR_W +: ADDR_W];
      hit_end    = EDGES[(int'(hit_idx)+1)*ADDR_W +: ADDR_W];
      local_full = DL_ADDR - hit_base;
      is_last    = (local_full == (hit_end - hit_base - ADDR_W'(1)));
      hit_onehot = NUM_REGIONS'(1) << hit_idx;
      in_range   = (DL_ADDR < REGION_LIMIT);
      accept     = DL_WR & in_range & (state_q == LOAD);
      // The first byte of a download has no predecessor to compare against.
      non_mono   = (BYTE_CNT != '0) && (DL_ADDR <= last_addr);
      err_evt    = DL_WR & ((state_q != LOAD) | ~in_range | non_mono);
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RESET_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state; a new rising edge of DL_ACTIVE in FINISH starts the next download directly.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = LOAD;
               start   = 1'b1;
            end
         end
         LOAD: begin
            if (!DL_ACTIVE) state_d = FINISH;
         end
         FINISH: begin
            if (rise) begin
               state_d = LOAD;
               start   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Write port, progress tracking and error flag. In reset, act_q follows DL_ACTIVE so a
   // level held high across reset is not mistaken for a new download start.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         act_q      <= DL_ACTIVE;
         WR_EN      <= 1'b0;
         WR_CS      <= '0;
         WR_ADDR    <= '0;
         WR_DATA    <= '0;
         REGION_IDX <= '0;
         LOADED     <= '0;
         DL_ERR     <= 1'b0;
         BYTE_CNT   <= '0;
         CHECKSUM   <= '0;
         last_addr  <= '0;
      end else begin
         act_q <= DL_ACTIVE;
         WR_EN <= accept;
         WR_CS <= accept ? hit_onehot : '0;
         if (accept) begin
            WR_ADDR    <= local_full[LOCAL_AW-1:0];
            WR_DATA    <= DL_DATA;
            REGION_IDX <= hit_idx;
            last_addr  <= DL_ADDR;
            CHECKSUM   <= CHECKSUM + DL_DATA;
            if (~&BYTE_CNT) BYTE_CNT <= BYTE_CNT + ADDR_W'(1);
            // Completion only counts if the download was clean up to this byte.
            if (is_last && !DL_ERR) LOADED <= LOADED | hit_onehot;
         end
         if (start) begin
            LOADED    <= '0;
            BYTE_CNT  <= '0;
            CHECKSUM  <= '0;
            last_addr <= '0;
            // A byte arriving on the start cycle itself is still outside LOAD.
            DL_ERR    <= DL_WR;
         end else if (err_evt) begin
            DL_ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_router.sv
// Purpose: directed self-checking bench for rom_dl_router with default parameters.
// Latency: expects write outputs one cycle after each DL_WR, sampled 1ns after the edge.
// Backpressure: none exercised; the DUT has no ready and bytes are streamed every cycle.
module tb_rom_dl_router;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        DL_ACTIVE;
   logic        DL_WR;
   logic [24:0] DL_ADDR;
   logic [7:0]  DL_DATA;
   logic        WR_EN;
   logic [3:0]  WR_CS;
   logic [14:0] WR_ADDR;
   logic [7:0]  WR_DATA;
   logic [1:0]  REGION_IDX;
   logic [3:0]  LOADED;
   logic        DL_DONE;
   logic        DL_ERR;
   logic [24:0] BYTE_CNT;
   logic [7:0]  CHECKSUM;

   int total = 0;
   int bad   = 0;

   rom_dl_router dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .DL_ACTIVE  (DL_ACTIVE),
      .DL_WR      (DL_WR),
      .DL_ADDR    (DL_ADDR),
      .DL_DATA    (DL_DATA),
      .WR_EN      (WR_EN),
      .WR_CS      (WR_CS),
      .WR_ADDR    (WR_ADDR),
      .WR_DATA    (WR_DATA),
      .REGION_IDX (REGION_IDX),
      .LOADED     (LOADED),
      .DL_DONE    (DL_DONE),
      .DL_ERR     (DL_ERR),
      .BYTE_CNT   (BYTE_CNT),
      .CHECKSUM   (CHECKSUM)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [24:0] a, input logic [7:0] d);
      DL_WR   = 1'b1;
      DL_ADDR = a;
      DL_DATA = d;
      tick();
      DL_WR   = 1'b0;
   endtask

   initial begin
      int          miss;
      logic [3:0]  exp_cs;
      logic [24:0] exp_base;

      RESET_N = 1'b0; DL_ACTIVE = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
      tick(); tick();
      chk("rst_wr_en",    32'(WR_EN),    32'h0);
      chk("rst_wr_cs",    32'(WR_CS),    32'h0);
      chk("rst_loaded",   32'(LOADED),   32'h0);
      chk("rst_done",     32'(DL_DONE),  32'h0);
      chk("rst_err",      32'(DL_ERR),   32'h0);
      chk("rst_byte_cnt", 32'(BYTE_CNT), 32'h0);
      chk("rst_checksum", 32'(CHECKSUM), 32'h0);
      RESET_N = 1'b1;
      tick();

      // ---- full download, data = addr[7:0], one byte per cycle
      DL_ACTIVE = 1'b1;
      tick();
      miss = 0;
      for (int a = 0; a < 32'h14000; a++) begin
         DL_WR = 1'b1; DL_ADDR = 25'(a); DL_DATA = 8'(a);
         tick();
         if (a >= 32'h12000)      begin exp_cs = 4'b1000; exp_base = 25'h12000; end
         else if (a >= 32'h10000) begin exp_cs = 4'b0100; exp_base = 25'h10000; end
         else if (a >= 32'h08000) begin exp_cs = 4'b0010; exp_base = 25'h08000; end
         else                     begin exp_cs = 4'b0001; exp_base = 25'h00000; end
         if (WR_EN !== 1'b1 || WR_CS !== exp_cs || WR_ADDR !== 15'(25'(a) - exp_base) ||
             WR_DATA !== 8'(a) || DL_DONE !== 1'b0 || DL_ERR !== 1'b0) miss++;
         if (a inside {32'h07FFF, 32'h08000, 32'h10000, 32'h12000}) begin
            chk("full_cs_boundary",   32'(WR_CS),   32'(exp_cs));
            chk("full_addr_boundary", 32'(WR_ADDR), 32'(25'(a) - exp_base));
         end
      end
      chk("full_stream_misses", 32'(miss), 32'h0);
      chk("full_region_idx", 32'(REGION_IDX), 32'h3);
      DL_WR = 1'b0; DL_ACTIVE = 1'b0;
      tick();
      chk("full_done_pulse", 32'(DL_DONE),  32'h1);
      chk("full_loaded",     32'(LOADED),   32'hF);
      chk("full_byte_cnt",   32'(BYTE_CNT), 32'h14000);
      chk("full_checksum",   32'(CHECKSUM), 32'h00);
      chk("full_wr_en_idle", 32'(WR_EN),    32'h0);
      tick();
      chk("full_done_once",  32'(DL_DONE),  32'h0);

      // ---- single byte at 0x10005
      DL_ACTIVE = 1'b1;
      tick();
      chk("start_clr_loaded", 32'(LOADED),   32'h0);
      chk("start_clr_cnt",    32'(BYTE_CNT), 32'h0);
      chk("start_clr_cks",    32'(CHECKSUM), 32'h0);
      wr(25'h10005, 8'hA5);
      chk("one_wr_en",   32'(WR_EN),      32'h1);
      chk("one_wr_cs",   32'(WR_CS),      32'h4);
      chk("one_wr_addr", 32'(WR_ADDR),    32'h5);
      chk("one_wr_data", 32'(WR_DATA),    32'hA5);
      chk("one_idx",     32'(REGION_IDX), 32'h2);
      chk("one_cks",     32'(CHECKSUM),   32'hA5);
      chk("one_cnt",     32'(BYTE_CNT),   32'h1);
      chk("one_loaded",  32'(LOADED),     32'h0);
      tick();
      chk("one_strobe_drop", 32'(WR_EN), 32'h0);
      chk("one_cs_drop",     32'(WR_CS), 32'h0);

      // ---- out of range write
      wr(25'h14000, 8'h33);
      chk("oor_wr_en", 32'(WR_EN),    32'h0);
      chk("oor_err",   32'(DL_ERR),   32'h1);
      chk("oor_cnt",   32'(BYTE_CNT), 32'h1);
      chk("oor_cks",   32'(CHECKSUM), 32'hA5);
      DL_ACTIVE = 1'b0;
      tick(); tick();
      DL_ACTIVE = 1'b1;
      tick();
      chk("oor_err_cleared", 32'(DL_ERR), 32'h0);

      // ---- region 2 tail then a backwards address
      DL_WR = 1'b1; DL_ADDR = 25'h11FFE; DL_DATA = 8'h01;
      tick();
      chk("tail_addr_1ffe", 32'(WR_ADDR), 32'h1FFE);
      chk("tail_loaded_0",  32'(LOADED),  32'h0);
      DL_ADDR = 25'h11FFF; DL_DATA = 8'h02;
      tick();
      chk("tail_wr_en_b2b", 32'(WR_EN),   32'h1);
      chk("tail_loaded_2",  32'(LOADED),  32'h4);
      chk("tail_err_clean", 32'(DL_ERR),  32'h0);
      DL_ADDR = 25'h00010; DL_DATA = 8'h03;
      tick();
      DL_WR = 1'b0;
      chk("back_wr_en",   32'(WR_EN),    32'h1);
      chk("back_wr_cs",   32'(WR_CS),    32'h1);
      chk("back_wr_addr", 32'(WR_ADDR),  32'h10);
      chk("back_err",     32'(DL_ERR),   32'h1);
      chk("back_cnt",     32'(BYTE_CNT), 32'h3);
      chk("back_cks",     32'(CHECKSUM), 32'h06);
      chk("back_loaded",  32'(LOADED),   32'h4);
      DL_ACTIVE = 1'b0;
      tick(); tick();

      // ---- reset in the middle of a download with DL_ACTIVE held high
      DL_ACTIVE = 1'b1;
      tick();
      wr(25'h09000, 8'h3C);
      chk("mid_wr_cs",   32'(WR_CS),   32'h2);
      chk("mid_wr_addr", 32'(WR_ADDR), 32'h1000);
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      chk("mid_rst_outputs",
          32'({WR_EN, WR_CS, WR_ADDR, WR_DATA, REGION_IDX}), 32'h0);
      chk("mid_rst_status", 32'({LOADED, DL_DONE, DL_ERR, CHECKSUM}), 32'h0);
      chk("mid_rst_cnt",    32'(BYTE_CNT), 32'h0);
      wr(25'h09001, 8'h11);
      chk("mid_stray_wr_en", 32'(WR_EN),    32'h0);
      chk("mid_stray_err",   32'(DL_ERR),   32'h1);
      chk("mid_stray_cnt",   32'(BYTE_CNT), 32'h0);
      tick();
      wr(25'h09002, 8'h11);
      chk("mid_still_idle", 32'(WR_EN), 32'h0);
      DL_ACTIVE = 1'b0;
      tick();
      DL_ACTIVE = 1'b1;
      tick();
      chk("mid_restart_err", 32'(DL_ERR), 32'h0);
      wr(25'h09003, 8'h22);
      chk("mid_resume_wr_en", 32'(WR_EN),   32'h1);
      chk("mid_resume_addr",  32'(WR_ADDR), 32'h1003);
      chk("mid_resume_cnt",   32'(BYTE_CNT), 32'h1);

      // ---- FINISH directly back into LOAD
      DL_ACTIVE = 1'b0;
      tick();
      chk("fin_done",    32'(DL_DONE),  32'h1);
      chk("fin_cnt",     32'(BYTE_CNT), 32'h1);
      DL_ACTIVE = 1'b1;
      tick();
      chk("fin_done_once", 32'(DL_DONE),  32'h0);
      chk("fin_clr_cnt",   32'(BYTE_CNT), 32'h0);
      chk("fin_clr_cks",   32'(CHECKSUM), 32'h0);
      wr(25'h00000, 8'h77);
      chk("fin_first_wr_en", 32'(WR_EN),    32'h1);
      chk("fin_first_cnt",   32'(BYTE_CNT), 32'h1);
      chk("fin_first_cks",   32'(CHECKSUM), 32'h77);
      chk("fin_first_err",   32'(DL_ERR),   32'h0);
      DL_ACTIVE = 1'b0;
      tick();
      chk("end_done", 32'(DL_DONE), 32'h1);
      tick();
      chk("end_done_clear", 32'(DL_DONE), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
